// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-word reads to instruction memory,
// captures the returned word and reports misaligned or timed-out fetches as faults.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [31:0] pc_load_val,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] instruction_out,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_out,
  output logic        fetch_done,
  output logic        fetch_fault,
  output logic        fault_misaligned,
  output logic        busy
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      instr_pc_q, instr_pc_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             fault_mis_q, fault_mis_d;
  logic [31:0]      eff_pc;
  logic             eff_misaligned;

  // A fetch requested together with a load targets the freshly loaded address.
  assign eff_pc         = pc_load ? pc_load_val : pc_q;
  assign eff_misaligned = (eff_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      ir_q        <= NOP_INSTR;
      instr_pc_q  <= RESET_PC;
      wait_cnt_q  <= '0;
      fault_mis_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      instr_pc_q  <= instr_pc_d;
      wait_cnt_q  <= wait_cnt_d;
      fault_mis_q <= fault_mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (fetch_req) begin
          state_d = eff_misaligned ? S_FAULT : S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        // A response on the final allowed cycle beats the timeout.
        if (imem_rvalid) begin
          state_d = S_DONE;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    ir_d        = ir_q;
    instr_pc_d  = instr_pc_q;
    wait_cnt_d  = wait_cnt_q;
    fault_mis_d = fault_mis_q;
    unique case (state_q)
      S_IDLE: begin
        if (pc_load) begin
          pc_d = pc_load_val;
        end
        if (fetch_req && eff_misaligned) begin
          fault_mis_d = 1'b1;
        end
      end
      S_REQ: wait_cnt_d = '0;
      S_WAIT: begin
        if (imem_rvalid) begin
          ir_d       = imem_rdata;
          instr_pc_d = pc_q;
          pc_d       = pc_q + 32'd4;
        end else if (wait_cnt_q == CNT_LAST) begin
          fault_mis_d = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    imem_req         = (state_q == S_REQ);
    imem_addr        = (state_q == S_REQ) ? pc_q : 32'h0;
    fetch_done       = (state_q == S_DONE);
    fetch_fault      = (state_q == S_FAULT);
    busy             = (state_q != S_IDLE);
    instruction_out  = ir_q;
    instr_pc         = instr_pc_q;
    pc_out           = pc_q;
    fault_misaligned = fault_mis_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (TIMEOUT 16 and 4), a cycle-timeline model
// of expected outputs checked every cycle, plus literal checks of the directed scenarios.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        fr[2], pl[2], rv[2];
  logic [31:0] plv[2], rd[2];
  logic        o_req[2], o_done[2], o_fault[2], o_mis[2], o_busy[2];
  logic [31:0] o_addr[2], o_ins[2], o_ipc[2], o_pc[2];

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut0 (
    .clk(clk), .reset(rst), .fetch_req(fr[0]), .pc_load(pl[0]), .pc_load_val(plv[0]),
    .imem_req(o_req[0]), .imem_addr(o_addr[0]), .imem_rdata(rd[0]), .imem_rvalid(rv[0]),
    .instruction_out(o_ins[0]), .instr_pc(o_ipc[0]), .pc_out(o_pc[0]),
    .fetch_done(o_done[0]), .fetch_fault(o_fault[0]), .fault_misaligned(o_mis[0]),
    .busy(o_busy[0]));

  instr_fetch_unit #(.RESET_PC(32'h0000_0200), .TIMEOUT(4)) dut1 (
    .clk(clk), .reset(rst), .fetch_req(fr[1]), .pc_load(pl[1]), .pc_load_val(plv[1]),
    .imem_req(o_req[1]), .imem_addr(o_addr[1]), .imem_rdata(rd[1]), .imem_rvalid(rv[1]),
    .instruction_out(o_ins[1]), .instr_pc(o_ipc[1]), .pc_out(o_pc[1]),
    .fetch_done(o_done[1]), .fetch_fault(o_fault[1]), .fault_misaligned(o_mis[1]),
    .busy(o_busy[1]));

  // Model: architectural registers plus the per-cycle strobes expected right now.
  logic [31:0] m_pc[2], m_ir[2], m_ipc[2];
  logic        m_mis[2];
  logic        e_busy[2], e_req[2], e_done[2], e_fault[2];
  logic [31:0] e_addr[2];
  logic        chk_en = 1'b0;
  logic [31:0] addrs0[$];
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic int to_of(input int d);
    return (d == 0) ? 16 : 4;
  endfunction

  function automatic logic [31:0] rst_pc_of(input int d);
    return (d == 0) ? 32'h0000_0000 : 32'h0000_0200;
  endfunction

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, d, $time, act, exp);
    end
  endtask

  task automatic set_exp(input int d, input logic b, input logic r, input logic [31:0] a,
                         input logic dn, input logic f);
    e_busy[d] = b; e_req[d] = r; e_addr[d] = a; e_done[d] = dn; e_fault[d] = f;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = rst_pc_of(d); m_ir[d] = 32'h0000_0013; m_ipc[d] = rst_pc_of(d); m_mis[d] = 1'b0;
      set_exp(d, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check("busy", d, 32'(o_busy[d]), 32'(e_busy[d]));
        check("imem_req", d, 32'(o_req[d]), 32'(e_req[d]));
        check("imem_addr", d, o_addr[d], e_addr[d]);
        check("fetch_done", d, 32'(o_done[d]), 32'(e_done[d]));
        check("fetch_fault", d, 32'(o_fault[d]), 32'(e_fault[d]));
        check("fault_misaligned", d, 32'(o_mis[d]), 32'(m_mis[d]));
        check("instruction_out", d, o_ins[d], m_ir[d]);
        check("instr_pc", d, o_ipc[d], m_ipc[d]);
        check("pc_out", d, o_pc[d], m_pc[d]);
      end
      if (o_req[0]) addrs0.push_back(o_addr[0]);
    end
  end

  // Entered at the start of an IDLE cycle; returns at the start of the following IDLE cycle.
  // lat = cycles from imem_req to imem_rvalid (0 = never answer); noise toggles ignored inputs.
  task automatic do_fetch(input int d, input logic ld, input logic [31:0] lv, input int lat,
                          input logic [31:0] data, input logic noise);
    bit got = 0;
    fr[d] = 1'b1; pl[d] = ld; plv[d] = lv;
    step();
    fr[d] = 1'b0; pl[d] = 1'b0;
    if (ld) m_pc[d] = lv;
    if (m_pc[d][1:0] != 2'b00) begin
      m_mis[d] = 1'b1;
      set_exp(d, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      step();
      set_exp(d, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      return;
    end
    set_exp(d, 1'b1, 1'b1, m_pc[d], 1'b0, 1'b0);
    step();
    for (int w = 0; w < to_of(d) && !got; w++) begin
      set_exp(d, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      fr[d] = noise; pl[d] = noise; plv[d] = 32'hFFFF_FFF0;
      if (lat == w + 1) begin rv[d] = 1'b1; rd[d] = data; end
      else rd[d] = 32'hDEAD_0000 | 32'(w);
      step();
      rv[d] = 1'b0; fr[d] = 1'b0; pl[d] = 1'b0;
      if (lat == w + 1) got = 1;
    end
    if (got) begin
      m_ir[d] = data; m_ipc[d] = m_pc[d]; m_pc[d] = m_pc[d] + 32'd4;
      set_exp(d, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    end else begin
      m_mis[d] = 1'b0;
      set_exp(d, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    end
    step();
    set_exp(d, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      fr[d] = 1'b0; pl[d] = 1'b0; rv[d] = 1'b0; plv[d] = 32'h0; rd[d] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_en = 1'b1;
    step();
    rst = 1'b1;
    step();

    // First fetch after reset, then two more back-to-back with longer latency.
    do_fetch(0, 1'b0, 32'h0, 1, 32'h00A0_0093, 1'b0);
    check("lit_ir_first", 0, o_ins[0], 32'h00A0_0093);
    check("lit_ipc_first", 0, o_ipc[0], 32'h0);
    check("lit_pc_first", 0, o_pc[0], 32'h4);
    do_fetch(0, 1'b0, 32'h0, 3, 32'h0011_0113, 1'b0);
    do_fetch(0, 1'b0, 32'h0, 5, 32'h0021_8193, 1'b1);
    check("lit_addr_count", 0, 32'(addrs0.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check("lit_addr_seq", 0, (i < addrs0.size()) ? addrs0[i] : 32'hFFFF_FFFF, 32'(4 * i));
    check("lit_pc_after3", 0, o_pc[0], 32'hC);
    addrs0.delete();

    // Load and fetch in the same IDLE cycle.
    do_fetch(0, 1'b1, 32'h100, 2, 32'h0030_0213, 1'b0);
    check("lit_addr_load", 0, (addrs0.size() > 0) ? addrs0[0] : 32'hFFFF_FFFF, 32'h100);
    check("lit_pc_load", 0, o_pc[0], 32'h104);
    addrs0.delete();

    // Misaligned fetch: fault without a memory request.
    do_fetch(0, 1'b1, 32'h102, 1, 32'h0, 1'b0);
    check("lit_mis_flag", 0, 32'(o_mis[0]), 32'd1);
    check("lit_mis_ir", 0, o_ins[0], 32'h0030_0213);
    check("lit_mis_noreq", 0, 32'(addrs0.size()), 32'd0);

    // Timeout on the TIMEOUT=4 instance, then a stray late response.
    do_fetch(1, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    check("lit_to_mis", 1, 32'(o_mis[1]), 32'd0);
    check("lit_to_pc", 1, o_pc[1], 32'h200);
    step();
    rv[1] = 1'b1; rd[1] = 32'hBAD0_BAD0;
    step();
    rv[1] = 1'b0;
    check("lit_stray_ir", 1, o_ins[1], 32'h0000_0013);

    // Response on the last allowed WAIT cycle is captured.
    do_fetch(1, 1'b0, 32'h0, 4, 32'h0050_0293, 1'b0);
    check("lit_last_ir", 1, o_ins[1], 32'h0050_0293);
    check("lit_last_pc", 1, o_pc[1], 32'h204);

    // Reset asserted during WAIT.
    fr[0] = 1'b1; pl[0] = 1'b1; plv[0] = 32'h40;
    step();
    fr[0] = 1'b0; pl[0] = 1'b0; m_pc[0] = 32'h40;
    set_exp(0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
    step();
    set_exp(0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    model_reset();
    rv[0] = 1'b1; rd[0] = 32'hFFFF_FFFF;
    check("lit_rst_busy", 0, 32'(o_busy[0]), 32'd0);
    check("lit_rst_pc", 0, o_pc[0], 32'h0);
    check("lit_rst_ir", 0, o_ins[0], 32'h0000_0013);
    step();
    rv[0] = 1'b0;
    step();
    check("lit_rst_late_ir", 0, o_ins[0], 32'h0000_0013);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that sits directly upstream of the multi-cycle control unit. It owns the program counter and issues word reads to instruction memory over a variable-latency request/valid interface. It captures the returned word into the instruction register and hands `instruction_out` plus its PC to the control/datapath with a one-cycle completion pulse. Misaligned PCs and memory timeouts are reported as faults instead of hanging the state machine.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `TIMEOUT`, default 16: maximum number of WAIT cycles allowed for `imem_rvalid`; legal range ≥ 2.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset. Sampled on `clk`; low = reset.
- `fetch_req`  in  1  start a fetch. Sampled only in IDLE.
- `pc_load`  in  1  load `pc_load_val` into PC. Honoured only in IDLE.
- `pc_load_val`  in  32  new PC value for branches and jumps.
- `imem_req`  out  1  instruction memory read strobe, one cycle wide.
- `imem_addr`  out  32  read address; equals PC while `imem_req` = 1, 0 otherwise.
- `imem_rdata`  in  32  read data; valid only when `imem_rvalid` = 1.
- `imem_rvalid`  in  1  read data valid, one cycle; latency ≥ 1 cycle after `imem_req`.
- `instruction_out`  out  32  instruction register contents.
- `instr_pc`  out  32  PC of the instruction held in `instruction_out`.
- `pc_out`  out  32  current PC, which is the next fetch address.
- `fetch_done`  out  1  one-cycle pulse when a new instruction has been captured.
- `fetch_fault`  out  1  one-cycle pulse when a fetch aborts.
- `fault_misaligned`  out  1  cause of the last fault: 1 = misaligned, 0 = timeout. Held until the next fault.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, REQ, WAIT, DONE, FAULT.
- IDLE:
  - `pc_load` = 1 sets PC to `pc_load_val`.
  - `fetch_req` = 1 means the effective PC is `pc_load_val` if `pc_load` = 1 in the same cycle, otherwise PC.
  - If effective PC[1:0] ≠ 0: go to FAULT and set `fault_misaligned` = 1. No memory request is issued.
  - Otherwise go to REQ.
- REQ:
  - Drive `imem_req` = 1 and `imem_addr` = PC for exactly one cycle.
  - Clear `wait_cnt` to 0, then go to WAIT.
- WAIT:
  - If `imem_rvalid` = 1: IR ← `imem_rdata`, `instr_pc` ← PC, PC ← PC + 4 (mod 2^32, wraps from 32'hFFFF_FFFC to 0). Go to DONE.
  - Else if `wait_cnt` = TIMEOUT−1: go to FAULT and set `fault_misaligned` = 0. PC and IR are unchanged.
  - Else increment `wait_cnt`.
  - `wait_cnt` width is $clog2(TIMEOUT).
- DONE: `fetch_done` = 1, then go to IDLE.
- FAULT: `fetch_fault` = 1, then go to IDLE.
- Boundary conditions:
  - `fetch_req` or `pc_load` outside IDLE is ignored; it is not queued.
  - `imem_rvalid` outside WAIT is ignored. A late response after a timeout does not update IR.
  - If `imem_rvalid` arrives on the last allowed WAIT cycle (`wait_cnt` = TIMEOUT−1), the capture wins over the timeout.
  - Reset asserted mid-fetch returns to IDLE on the next edge. Any outstanding response is then ignored.

## Timing
- Reset values:
  - state = IDLE
  - PC = `RESET_PC`
  - IR = 32'h0000_0013 (addi x0,x0,0)
  - `instr_pc` = `RESET_PC`
  - `imem_req` = 0, `imem_addr` = 0
  - `fetch_done` = 0, `fetch_fault` = 0, `fault_misaligned` = 0, `busy` = 0
- Outputs are Moore, decoded from registered state and registers. Nothing combinational passes from inputs to outputs.
- Latency, with `fetch_req` accepted at cycle 0:
  - `imem_req` is high at cycle 1.
  - With `imem_rvalid` at cycle 1+L (L ≥ 1), IR, `instr_pc` and PC update at the end of that cycle.
  - `fetch_done` is high at cycle 2+L. The earliest `fetch_done` is cycle 3.
  - The next `fetch_req` is accepted at cycle 3+L.
- Timeout: `imem_req` at cycle 1 with no response gives `fetch_fault` at cycle 2+TIMEOUT.
- Misaligned fetch: `fetch_fault` at cycle 1; `imem_req` never asserts.

## Test plan
- Reset, then pulse `fetch_req`; memory returns 32'h00A00093 at L = 1. Required: `imem_addr` = 0 at cycle 1, `fetch_done` at cycle 3, `instruction_out` = 32'h00A00093, `instr_pc` = 0, `pc_out` = 4.
- Issue 3 back-to-back fetches with L = 1, 3 and 5. Required: addresses 0, 4 and 8; PC ends at 12; each `fetch_done` is exactly one cycle wide.
- `pc_load` = 1 with `pc_load_val` = 32'h100 and `fetch_req` = 1 in the same IDLE cycle. Required: `imem_addr` = 32'h100, then `pc_out` = 32'h104 after capture.
- `pc_load_val` = 32'h102 with `fetch_req`. Required: `fetch_fault` at cycle 1, `fault_misaligned` = 1, `imem_req` stays 0, IR unchanged.
- TIMEOUT = 4 with no `imem_rvalid`. Required: `fetch_fault` at cycle 6, `fault_misaligned` = 0, PC unchanged. A stray `imem_rvalid` at cycle 8 leaves IR unchanged. In a second run, `imem_rvalid` on the 4th WAIT cycle is captured and no fault is raised.
- Assert `reset` low during WAIT. Required: the next cycle shows IDLE with `busy` = 0, PC = `RESET_PC`, IR = 32'h00000013.
